// File: rtl/gearbox_pkg.sv
// gearbox_pkg: shared sizing helpers and drain-FSM state type for the N-to-M word gearbox
package gearbox_pkg;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) ;
        return r;
    endfunction
    function automatic int cnt_w(input int cap);
        return clog2(cap + 1);
    endfunction
    function automatic int def_cap(input int in_words, input int out_words);
        return in_words + out_words;
    endfunction
    typedef enum logic {GB_RUN, GB_DRAIN} gb_state_t;
endpackage

// File: rtl/gearbox_word_buffer.sv
// gearbox_word_buffer: word-granular shift buffer with occupancy count
// Ports: clk, arst (async, active-low); din (IN_WORDS words); accept/consume strobes;
//        dout = buffer words 0..OUT_WORDS-1 (registered); count = occupied words.
module gearbox_word_buffer import gearbox_pkg::*; #(
    parameter int WORD_LEN  = 16,
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 20,
    parameter int CAP_WORDS = 28,
    parameter int CW        = cnt_w(CAP_WORDS)
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [IN_WORDS*WORD_LEN-1:0]  din,
    input  logic                          accept,
    input  logic                          consume,
    output logic [OUT_WORDS*WORD_LEN-1:0] dout,
    output logic [CW-1:0]                 count
);
    localparam int BW = CAP_WORDS * WORD_LEN;
    logic [BW-1:0] mem, shifted, nxt;
    logic [CW-1:0] base, nxt_cnt;
    // Words at or above count are always zero, so new words can be OR-ed in.
    // A consume of a partial (flush) beat saturates count at zero.
    always_comb begin
        shifted = consume ? mem >> (OUT_WORDS * WORD_LEN) : mem;
        base    = !consume ? count : (count > CW'(OUT_WORDS)) ? count - CW'(OUT_WORDS) : '0;
        nxt     = accept ? shifted | (BW'(din) << (WORD_LEN * int'(base))) : shifted;
        nxt_cnt = accept ? base + CW'(IN_WORDS) : base;
    end
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            mem   <= '0;
            count <= '0;
        end else begin
            mem   <= nxt;
            count <= nxt_cnt;
        end
    end
    assign dout = mem[OUT_WORDS*WORD_LEN-1:0];
endmodule

// File: rtl/gearbox_n_to_m.sv
// gearbox_n_to_m: repacks IN_WORDS-word beats into OUT_WORDS-word beats with valid/ready on both sides
// Ports: clk, arst (async, active-low); din/din_valid/din_ready input beat;
//        dout/dout_valid/dout_ready output beat; words_held = buffer occupancy.
// Macro GEARBOX_FLUSH_EN adds din_last/dout_last and a drain FSM that emits a zero-padded final beat.
module gearbox_n_to_m import gearbox_pkg::*; #(
    parameter int WORD_LEN  = 16,
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 20,
    parameter int CAP_WORDS = def_cap(IN_WORDS, OUT_WORDS)
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [IN_WORDS*WORD_LEN-1:0]  din,
    input  logic                          din_valid,
    output logic                          din_ready,
`ifdef GEARBOX_FLUSH_EN
    input  logic                          din_last,
    output logic                          dout_last,
`endif
    output logic [OUT_WORDS*WORD_LEN-1:0] dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [cnt_w(CAP_WORDS)-1:0]   words_held
);
    localparam int CW = cnt_w(CAP_WORDS);
    if (IN_WORDS < 1 || OUT_WORDS < 1 || CAP_WORDS < IN_WORDS + OUT_WORDS - 1) begin : g_bad_cfg
        $error("gearbox_n_to_m: invalid IN_WORDS/OUT_WORDS/CAP_WORDS");
    end
    logic [CW-1:0] count;
    logic room, full, accept, consume;
    // Both handshake outputs come from registered count/state only.
    assign room       = count <= CW'(CAP_WORDS - IN_WORDS);
    assign full       = count >= CW'(OUT_WORDS);
    assign accept     = din_valid & din_ready;
    assign consume    = dout_valid & dout_ready;
    assign words_held = count;
`ifdef GEARBOX_FLUSH_EN
    gb_state_t state, state_d;
    assign din_ready  = room && state == GB_RUN;
    assign dout_valid = full || (state == GB_DRAIN && count != '0);
    assign dout_last  = state == GB_DRAIN && count != '0 && count <= CW'(OUT_WORDS);
    always_comb begin
        state_d = (state == GB_RUN && accept && din_last) ? GB_DRAIN : (consume && dout_last) ? GB_RUN : state;
    end
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= GB_RUN;
        else state <= state_d;
    end
`else
    assign din_ready  = room;
    assign dout_valid = full;
`endif
    gearbox_word_buffer #(
        .WORD_LEN(WORD_LEN), .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS), .CAP_WORDS(CAP_WORDS), .CW(CW)
    ) u_buf (
        .clk(clk), .arst(arst), .din(din), .accept(accept), .consume(consume), .dout(dout), .count(count)
    );
endmodule

// File: tb/tb_gearbox_n_to_m.sv
// tb_gearbox_n_to_m: directed self-checking bench for gearbox_n_to_m (8->20, 20->8 and a chained pair)
module tb_gearbox_n_to_m;
    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic [127:0] a_din;  logic a_dv, a_dr, a_ov, a_or; logic [319:0] a_dout; logic [4:0] a_held;
    logic [319:0] b_din;  logic b_dv, b_dr, b_ov, b_or; logic [127:0] b_dout; logic [4:0] b_held;
    logic [127:0] c1_din; logic c1_dv, c1_dr, c_mv, c_mr; logic [319:0] c_mid; logic [4:0] c1_held;
    logic [127:0] c2_dout; logic c2_ov, c2_or; logic [4:0] c2_held;
`ifdef GEARBOX_FLUSH_EN
    logic a_last, a_olast, b_olast, c1_olast, c2_olast;
`endif
    gearbox_n_to_m #(.WORD_LEN(16), .IN_WORDS(8), .OUT_WORDS(20)) u_a (
        .clk(clk), .arst(arst), .din(a_din), .din_valid(a_dv), .din_ready(a_dr),
`ifdef GEARBOX_FLUSH_EN
        .din_last(a_last), .dout_last(a_olast),
`endif
        .dout(a_dout), .dout_valid(a_ov), .dout_ready(a_or), .words_held(a_held));
    gearbox_n_to_m #(.WORD_LEN(16), .IN_WORDS(20), .OUT_WORDS(8)) u_b (
        .clk(clk), .arst(arst), .din(b_din), .din_valid(b_dv), .din_ready(b_dr),
`ifdef GEARBOX_FLUSH_EN
        .din_last(1'b0), .dout_last(b_olast),
`endif
        .dout(b_dout), .dout_valid(b_ov), .dout_ready(b_or), .words_held(b_held));
    gearbox_n_to_m #(.WORD_LEN(16), .IN_WORDS(8), .OUT_WORDS(20)) u_c1 (
        .clk(clk), .arst(arst), .din(c1_din), .din_valid(c1_dv), .din_ready(c1_dr),
`ifdef GEARBOX_FLUSH_EN
        .din_last(1'b0), .dout_last(c1_olast),
`endif
        .dout(c_mid), .dout_valid(c_mv), .dout_ready(c_mr), .words_held(c1_held));
    gearbox_n_to_m #(.WORD_LEN(16), .IN_WORDS(20), .OUT_WORDS(8)) u_c2 (
        .clk(clk), .arst(arst), .din(c_mid), .din_valid(c_mv), .din_ready(c_mr),
`ifdef GEARBOX_FLUSH_EN
        .din_last(1'b0), .dout_last(c2_olast),
`endif
        .dout(c2_dout), .dout_valid(c2_ov), .dout_ready(c2_or), .words_held(c2_held));

    function automatic logic [319:0] mk(input int first, input int n);
        logic [319:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[j*16 +: 16] = 16'(first + j);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b0;
        a_din = '0; a_dv = 0; a_or = 0; b_din = '0; b_dv = 0; b_or = 0; c1_din = '0; c1_dv = 0; c2_or = 0;
`ifdef GEARBOX_FLUSH_EN
        a_last = 0;
`endif
        repeat (2) tick();
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b, expected 0", a_ov); end
        checks++; if (a_dr !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b, expected 1", a_dr); end
        checks++; if (a_held !== 5'd0) begin errors++; $display("FAIL reset_a_held: got %0d, expected 0", a_held); end
        checks++; if (a_dout !== '0) begin errors++; $display("FAIL reset_a_dout: got %h, expected 0", a_dout); end
        checks++; if (b_ov !== 1'b0 || b_dr !== 1'b1 || b_held !== 5'd0) begin
            errors++; $display("FAIL reset_b: got valid %b ready %b held %0d, expected 0 1 0", b_ov, b_dr, b_held); end
        @(negedge clk);
        arst = 1'b1;
        tick();
    endtask

    task automatic test_expand();
        int acc = 0, outs = 0, nxt = 1;
        a_or = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            a_dv = acc < 5;
            a_din = 128'(mk(nxt, 8));
            if (a_ov && a_or) begin
                checks++;
                if (a_dout !== mk(outs * 20 + 1, 20)) begin
                    errors++; $display("FAIL expand_beat%0d: got %h, expected %h", outs, a_dout, mk(outs * 20 + 1, 20)); end
                outs++;
            end
            if (a_dv && a_dr) begin acc++; nxt += 8; end
            tick();
        end
        a_dv = 0;
        checks++; if (acc != 5) begin errors++; $display("FAIL expand_accepted: got %0d, expected 5", acc); end
        checks++; if (outs != 2) begin errors++; $display("FAIL expand_out_beats: got %0d, expected 2", outs); end
        checks++; if (a_held !== 5'd0) begin errors++; $display("FAIL expand_held: got %0d, expected 0", a_held); end
    endtask

    task automatic test_reduce();
        int outs = 0, exp_w = 1;
        bit sent;
        b_or = 1;
        for (int p = 0; p < 2; p++) begin
            sent = 0;
            for (int cyc = 0; cyc < 8; cyc++) begin
                b_dv = !sent;
                b_din = mk(1 + 20 * p, 20);
                if (b_ov && b_or) begin
                    checks++;
                    if (b_dout !== 128'(mk(exp_w, 8))) begin
                        errors++; $display("FAIL reduce_beat%0d: got %h, expected %h", outs, b_dout, 128'(mk(exp_w, 8))); end
                    outs++; exp_w += 8;
                end
                if (b_dv && b_dr) sent = 1;
                tick();
            end
            b_dv = 0;
            checks++; if (outs != (p == 0 ? 2 : 5)) begin
                errors++; $display("FAIL reduce_beats_p%0d: got %0d, expected %0d", p, outs, p == 0 ? 2 : 5); end
            checks++; if (b_held !== (p == 0 ? 5'd4 : 5'd0)) begin
                errors++; $display("FAIL reduce_held_p%0d: got %0d, expected %0d", p, b_held, p == 0 ? 4 : 0); end
            checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL reduce_idle_valid_p%0d: got %b, expected 0", p, b_ov); end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0, nxt = 1;
        a_or = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a_dv = 1;
            a_din = 128'(mk(nxt, 8));
            if (a_ov) begin
                checks++;
                if (a_dout !== mk(1, 20)) begin errors++; $display("FAIL bp_stable_c%0d: got %h, expected %h", cyc, a_dout, mk(1, 20)); end
            end
            checks++;
            if (a_dr !== (a_held <= 5'd20)) begin
                errors++; $display("FAIL bp_ready_c%0d: got %b, expected %b at held %0d", cyc, a_dr, a_held <= 5'd20, a_held); end
            if (a_dv && a_dr) begin acc++; nxt += 8; end
            tick();
        end
        a_dv = 0;
        checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted: got %0d, expected 3", acc); end
        checks++; if (a_held !== 5'd24) begin errors++; $display("FAIL bp_held: got %0d, expected 24", a_held); end
        checks++; if (a_dr !== 1'b0 || a_ov !== 1'b1) begin
            errors++; $display("FAIL bp_flags: got ready %b valid %b, expected 0 1", a_dr, a_ov); end
    endtask

    task automatic test_reset_midstream();
        int acc = 0, outs = 0;
        a_or = 1;
        tick();
        a_or = 0; a_dv = 1; a_din = 128'(mk(25, 8));
        tick();
        a_dv = 0;
        checks++; if (a_held !== 5'd12) begin errors++; $display("FAIL mid_held_before: got %0d, expected 12", a_held); end
        #2 arst = 1'b0;
        #1;
        checks++; if (a_ov !== 1'b0 || a_dr !== 1'b1 || a_held !== 5'd0) begin
            errors++; $display("FAIL mid_async_reset: got valid %b ready %b held %0d, expected 0 1 0", a_ov, a_dr, a_held); end
        @(negedge clk);
        arst = 1'b1;
        tick();
        a_or = 1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a_dv = acc < 3;
            a_din = 128'(mk(101 + 8 * acc, 8));
            if (a_ov && a_or) begin
                checks++;
                if (a_dout !== mk(101, 20)) begin errors++; $display("FAIL mid_restart_beat: got %h, expected %h", a_dout, mk(101, 20)); end
                outs++;
            end
            if (a_dv && a_dr) acc++;
            tick();
        end
        a_dv = 0;
        checks++; if (outs != 1 || a_held !== 5'd4) begin
            errors++; $display("FAIL mid_restart_end: got beats %0d held %0d, expected 1 4", outs, a_held); end
    endtask

    task automatic test_chain();
        int nin = 1, nexp = 1;
        bit pending = 0, p1, p2;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!pending) begin
                c1_dv = 1'($urandom_range(0, 1));
                c1_din = 128'(mk(nin, 8));
            end
            p1 = c1_dr; p2 = c_mr;
            c2_or = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (c1_dr !== p1 || c_mr !== p2) begin
                errors++; $display("FAIL chain_ready_path_c%0d: got %b%b, expected %b%b", cyc, c1_dr, c_mr, p1, p2); end
            if (c2_ov && c2_or) begin
                checks++;
                if (c2_dout !== 128'(mk(nexp, 8))) begin
                    errors++; $display("FAIL chain_seq_c%0d: got %h, expected %h", cyc, c2_dout, 128'(mk(nexp, 8))); end
                nexp += 8;
            end
            if (c1_dv && c1_dr) begin nin += 8; pending = 0; end
            else pending = c1_dv;
            tick();
        end
        c1_dv = 0; c2_or = 0;
        checks++; if (nexp < 4000) begin errors++; $display("FAIL chain_progress: got %0d words, expected >= 4000", nexp - 1); end
    endtask

`ifdef GEARBOX_FLUSH_EN
    task automatic test_flush();
        int acc = 0, outs = 0;
        #2 arst = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        tick();
        a_or = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            a_dv = acc < 3;
            a_last = acc == 2;
            a_din = 128'(mk(1 + 8 * acc, 8));
            if (acc == 3 && outs < 2) begin
                checks++;
                if (a_dr !== 1'b0) begin errors++; $display("FAIL flush_ready_drain_c%0d: got %b, expected 0", cyc, a_dr); end
            end
            if (a_ov && a_or) begin
                checks++;
                if (a_dout !== (outs == 0 ? mk(1, 20) : mk(21, 4)) || a_olast !== (outs == 1)) begin
                    errors++; $display("FAIL flush_beat%0d: got %h last %b, expected %h last %b", outs, a_dout, a_olast,
                                       outs == 0 ? mk(1, 20) : mk(21, 4), outs == 1); end
                outs++;
            end
            if (a_dv && a_dr) acc++;
            tick();
        end
        a_dv = 0; a_last = 0;
        checks++; if (outs != 2 || a_dr !== 1'b1 || a_held !== 5'd0 || a_ov !== 1'b0) begin
            errors++; $display("FAIL flush_end: got beats %0d ready %b held %0d valid %b, expected 2 1 0 0", outs, a_dr, a_held, a_ov); end
    endtask
`endif

    initial begin
        test_reset();
        test_expand();
        test_reduce();
        test_backpressure();
        test_reset_midstream();
        test_chain();
`ifdef GEARBOX_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
